playlist_sequencer: RTL and testbench
=====================================

# playlist_sequencer

Playback controller that sequences the song-select index and note-ROM address for the music player. Takes single-cycle button pulses (play/pause, stop, next, prev) and an end-of-song flag from the note ROM. Runs a STOP/PLAY/PAUSE/GAP state machine with beat-rate address stepping, inter-song gaps and repeat modes. Sits between the debounced button front end and the note ROM / tone generator.

## Interface
- NUM_SONGS, 4, number of songs; indices 0..NUM_SONGS-1
- IDX_W, 2, width of song index, ≥ clog2(NUM_SONGS)
- ADDR_W, 7, note-address width
- BEAT_DIV, 25_000_000, clk cycles per beat (≥2)
- GAP_BEATS, 2, silent beats between songs (≥1)
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- play_btn  in  1  one-cycle pulse; toggles play/pause
- stop_btn  in  1  one-cycle pulse; stop and rewind
- next_btn  in  1  one-cycle pulse; next song
- prev_btn  in  1  one-cycle pulse; previous song
- repeat_mode  in  2  0 none, 1 all, 2 one, 3 treated as 0
- song_end  in  1  note ROM flags current note_addr as end marker (combinational from note_addr)
- song  out  IDX_W  current song index
- note_addr  out  ADDR_W  current note address
- beat  out  1  one-cycle strobe when note_addr advances or gap beat elapses
- playing  out  1  high in PLAY
- mute  out  1  high in every state except PLAY

## Operation
- States STOP, PLAY, PAUSE, GAP. Reset: STOP, song 0, note_addr 0, beat 0, playing 0, mute 1, beat counter 0.
- Button priority per cycle: stop > next > prev > play; lower-priority pulses in the same cycle are dropped. Any button beats song_end in the same cycle.
- stop_btn: any state → STOP, note_addr 0, beat counter cleared, song unchanged.
- next_btn/prev_btn: song ±1 modulo NUM_SONGS (NUM_SONGS-1→0 on next, 0→NUM_SONGS-1 on prev), note_addr 0, beat counter and gap count cleared. PLAY/GAP → GAP; STOP/PAUSE stay.
- play_btn: STOP→PLAY (note_addr 0); PLAY→PAUSE; PAUSE→PLAY; ignored in GAP.
- Beat counter runs 0..BEAT_DIV-1 in PLAY and GAP, holds in PAUSE, is 0 in STOP. Terminal count = beat tick.
- PLAY, beat tick, song_end=0: note_addr+1 (wraps at 2^ADDR_W), beat pulse.
- PLAY, beat tick, song_end=1: note_addr 0, beat pulse, then:
  - mode 2: same song → GAP
  - mode 1: song+1 wrapping → GAP
  - mode 0: if song = NUM_SONGS-1 → STOP, song 0; else song+1 → GAP
- GAP: beat pulse on every tick; after GAP_BEATS ticks → PLAY at note_addr 0.

## Timing
- All outputs registered. Button pulse in cycle N → song/note_addr/state visible in cycle N+1.
- Beat tick in cycle N (counter = BEAT_DIV-1) → beat high and note_addr updated in cycle N+1, for exactly one cycle.
- song_end sampled only in the tick cycle. Its value between ticks is ignored.
- First beat after STOP→PLAY or any song change arrives BEAT_DIV cycles after the state/song update.
- PAUSE→PLAY resumes the held count. The next beat arrives after the remaining BEAT_DIV-1-count cycles.
- Reset asserted mid-song returns all state immediately (asynchronously) to reset values.

## Configuration
- SHUFFLE_EN defined: adds input port shuffle (1 bit) and a free-running 8-bit Fibonacci LFSR.
  - LFSR taps 8,6,5,4; reset seed 8'hA5.
  - With shuffle=1, next_btn and mode-1/mode-0 auto-advance choose lfsr % NUM_SONGS. If that equals the current song, use +1 wrapping instead.
  - In mode 0 with shuffle, STOP occurs after NUM_SONGS auto-advances, tracked by a played counter that clears on STOP.
  - prev_btn always sequential.
- SHUFFLE_EN undefined: no shuffle port, no LFSR; sequential behaviour only.

## Structure
- Package playlist_pkg: state enum (STOP, PLAY, PAUSE, GAP), repeat-mode constants (RPT_NONE, RPT_ALL, RPT_ONE), LFSR seed and taps.
- Sub-module beat_timer: counter with enable, sync clear, hold, and a terminal-count output. Parameterised by BEAT_DIV. Instantiated once.

## Test plan (BEAT_DIV=4, GAP_BEATS=2, NUM_SONGS=4)
- Reset, then play_btn → playing=1 next cycle; beat every 4 cycles; note_addr 0,1,2,3.
- PLAY at note_addr 5, song 1, mode 1, song_end=1 at tick → note_addr 0, song 2, GAP. After 2 beats (8 cycles), PLAY.
- Song 3, mode 0, song_end at tick → STOP, song 0, mute=1, no further beats.
- Song 0, prev_btn and play_btn in the same cycle → song 3, play pulse dropped, state unchanged.
- PLAY with counter=2, play_btn → PAUSE, hold 10 cycles, play_btn → next beat 1 cycle after resume.
- Mode 2, song 2, song_end at tick → song stays 2, note_addr 0, GAP then PLAY; stop_btn during GAP → STOP, note_addr 0.

Source files
------------

// File: rtl/playlist_pkg.sv
// Shared types and constants for the playlist sequencer: FSM states, repeat modes and
// the shuffle LFSR seed/taps.
package playlist_pkg;

    typedef enum logic [1:0] {
        StStop,
        StPlay,
        StPause,
        StGap
    } state_e;

    localparam logic [1:0] RPT_NONE = 2'd0;
    localparam logic [1:0] RPT_ALL  = 2'd1;
    localparam logic [1:0] RPT_ONE  = 2'd2;

    // Fibonacci taps 8,6,5,4 expressed as a bit mask over lfsr[7:0]
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/playlist_sequencer_beat_timer.sv
// Beat-rate divider: counts 0..BEAT_DIV-1 while enabled, holds otherwise, and flags the
// terminal count as a single-cycle tick.
module beat_timer
    import playlist_pkg::*;
#(
    parameter int unsigned BEAT_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(BEAT_DIV);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            at_term;

    assign at_term = (cnt_q == CntW'(BEAT_DIV - 1));
    assign tick_o  = en_i && at_term;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_term ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/playlist_sequencer.sv
// Playback controller: STOP/PLAY/PAUSE/GAP sequencing of song index and note address.
// Optional shuffle support is compiled in with `define SHUFFLE_EN.
module playlist_sequencer
    import playlist_pkg::*;
#(
    parameter int unsigned NUM_SONGS = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned BEAT_DIV  = 25_000_000,
    parameter int unsigned GAP_BEATS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_btn_i,
    input  logic              stop_btn_i,
    input  logic              next_btn_i,
    input  logic              prev_btn_i,
    input  logic [1:0]        repeat_mode_i,
`ifdef SHUFFLE_EN
    input  logic              shuffle_i,
`endif
    input  logic              song_end_i,
    output logic [IDX_W-1:0]  song_o,
    output logic [ADDR_W-1:0] note_addr_o,
    output logic              beat_o,
    output logic              playing_o,
    output logic              mute_o
);

    localparam int unsigned GapW = $clog2(GAP_BEATS + 1);
    localparam logic [IDX_W-1:0] LastSong = IDX_W'(NUM_SONGS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  song_q, song_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic              beat_q, beat_d;
    logic              tick, timer_en, timer_clr;
    logic [IDX_W-1:0]  inc_song, dec_song, adv_song;
    logic              last_song;

    assign inc_song = (song_q == LastSong) ? '0 : song_q + IDX_W'(1);
    assign dec_song = (song_q == '0) ? LastSong : song_q - IDX_W'(1);

`ifdef SHUFFLE_EN
    logic [7:0]       lfsr_q;
    logic [IDX_W-1:0] played_q, played_d;
    logic [IDX_W-1:0] rand_song;
    logic             auto_adv;

    assign rand_song = IDX_W'({24'd0, lfsr_q} % NUM_SONGS);
    assign adv_song  = !shuffle_i ? inc_song : (rand_song == song_q) ? inc_song : rand_song;
    assign last_song = shuffle_i ? (played_q == LastSong) : (song_q == LastSong);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q   <= LFSR_SEED;
            played_q <= '0;
        end else begin
            lfsr_q   <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
            played_q <= played_d;
        end
    end

    always_comb begin
        played_d = played_q;
        if (state_d == StStop) begin
            played_d = '0;
        end else if (auto_adv && shuffle_i) begin
            played_d = played_q + IDX_W'(1);
        end
    end
`else
    assign adv_song  = inc_song;
    assign last_song = (song_q == LastSong);
`endif

    assign timer_en  = (state_q == StPlay) || (state_q == StGap);
    // Any song change, stop or idle state restarts the beat from zero
    assign timer_clr = stop_btn_i || next_btn_i || prev_btn_i || (state_q == StStop);

    beat_timer #(
        .BEAT_DIV (BEAT_DIV)
    ) u_beat_timer (
        .clk    (clk),
        .reset  (reset),
        .en_i   (timer_en),
        .clr_i  (timer_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        addr_d  = addr_q;
        gap_d   = gap_q;
        beat_d  = 1'b0;
`ifdef SHUFFLE_EN
        auto_adv = 1'b0;
`endif
        if (stop_btn_i) begin
            state_d = StStop;
            addr_d  = '0;
        end else if (next_btn_i || prev_btn_i) begin
            song_d = next_btn_i ? adv_song : dec_song;
            addr_d = '0;
            gap_d  = '0;
            if (state_q == StPlay || state_q == StGap) begin
                state_d = StGap;
            end
        end else if (play_btn_i && state_q != StGap) begin
            case (state_q)
                StStop: begin
                    state_d = StPlay;
                    addr_d  = '0;
                end
                StPlay:  state_d = StPause;
                default: state_d = StPlay;
            endcase
        end else if (tick) begin
            beat_d = 1'b1;
            if (state_q == StPlay) begin
                if (!song_end_i) begin
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    addr_d  = '0;
                    gap_d   = '0;
                    state_d = StGap;
                    case (repeat_mode_i)
                        RPT_ONE: ;
                        RPT_ALL: song_d = adv_song;
                        default: begin
                            if (last_song) begin
                                state_d = StStop;
                                song_d  = '0;
                            end else begin
                                song_d = adv_song;
`ifdef SHUFFLE_EN
                                auto_adv = 1'b1;
`endif
                            end
                        end
                    endcase
                end
            end else if (gap_q == GapW'(GAP_BEATS - 1)) begin
                state_d = StPlay;
                gap_d   = '0;
                addr_d  = '0;
            end else begin
                gap_d = gap_q + GapW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StStop;
            song_q  <= '0;
            addr_q  <= '0;
            gap_q   <= '0;
            beat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            addr_q  <= addr_d;
            gap_q   <= gap_d;
            beat_q  <= beat_d;
        end
    end

    assign song_o      = song_q;
    assign note_addr_o = addr_q;
    assign beat_o      = beat_q;
    assign playing_o   = (state_q == StPlay);
    assign mute_o      = (state_q != StPlay);

endmodule

// File: tb/tb_playlist_sequencer.sv
// Self-checking bench for playlist_sequencer: directed scenarios plus random button traffic,
// every cycle compared against a behavioural playback model.
module tb_playlist_sequencer;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int AW = 7;
    localparam int BD = 4;
    localparam int GB = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          play, stop, nxt, prv;
    logic [1:0]    mode;
    logic          song_end;
    logic [IW-1:0] song;
    logic [AW-1:0] note_addr;
    logic          beat, playing, mute;

    int checks = 0;
    int errors = 0;

    // Model: state 0=stop 1=play 2=pause 3=gap
    int m_state, m_song, m_addr, m_cnt, m_gap, m_beat;
    int end_at;

    always #5 clk = ~clk;

    playlist_sequencer #(
        .NUM_SONGS (N),
        .IDX_W     (IW),
        .ADDR_W    (AW),
        .BEAT_DIV  (BD),
        .GAP_BEATS (GB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .play_btn_i    (play),
        .stop_btn_i    (stop),
        .next_btn_i    (nxt),
        .prev_btn_i    (prv),
        .repeat_mode_i (mode),
        .song_end_i    (song_end),
        .song_o        (song),
        .note_addr_o   (note_addr),
        .beat_o        (beat),
        .playing_o     (playing),
        .mute_o        (mute)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_song = 0; m_addr = 0; m_cnt = 0; m_gap = 0; m_beat = 0;
    endtask

    task automatic model_step(input bit pl, input bit st, input bit nx, input bit pv,
                              input bit se, input int md);
        bit tick;
        int nc;
        tick = (m_state == 1 || m_state == 3) && (m_cnt == BD - 1);
        if (st || nx || pv || m_state == 0) nc = 0;
        else if (m_state == 2)              nc = m_cnt;
        else                                nc = (m_cnt + 1) % BD;
        if (md == 3) md = 0;
        m_beat = 0;
        if (st) begin
            m_state = 0;
            m_addr  = 0;
        end else if (nx || pv) begin
            m_song = nx ? (m_song + 1) % N : (m_song + N - 1) % N;
            m_addr = 0;
            m_gap  = 0;
            if (m_state == 1 || m_state == 3) m_state = 3;
        end else if (pl && m_state != 3) begin
            if (m_state == 0) begin
                m_state = 1;
                m_addr  = 0;
            end else begin
                m_state = (m_state == 1) ? 2 : 1;
            end
        end else if (tick) begin
            m_beat = 1;
            if (m_state == 1) begin
                if (!se) begin
                    m_addr = (m_addr + 1) % (1 << AW);
                end else begin
                    m_addr = 0;
                    m_gap  = 0;
                    if (md == 2) begin
                        m_state = 3;
                    end else if (md == 1 || m_song != N - 1) begin
                        m_song  = (m_song + 1) % N;
                        m_state = 3;
                    end else begin
                        m_state = 0;
                        m_song  = 0;
                    end
                end
            end else begin
                m_gap++;
                if (m_gap == GB) begin
                    m_gap   = 0;
                    m_state = 1;
                    m_addr  = 0;
                end
            end
        end
        m_cnt = nc;
    endtask

    task automatic compare_all();
        check_eq("song", int'(song), m_song);
        check_eq("note_addr", int'(note_addr), m_addr);
        check_eq("beat", int'(beat), m_beat);
        check_eq("playing", int'(playing), int'(m_state == 1));
        check_eq("mute", int'(mute), int'(m_state != 1));
    endtask

    // One clock: drive pulses, advance the model, compare at the falling edge
    task automatic cyc(input bit pl, input bit st, input bit nx, input bit pv);
        play = pl; stop = st; nxt = nx; prv = pv;
        song_end = (m_addr == end_at);
        model_step(pl, st, nx, pv, song_end, int'(mode));
        @(negedge clk);
        play = 0; stop = 0; nxt = 0; prv = 0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, ".song"}, int'(song), 0);
        check_eq({tag, ".addr"}, int'(note_addr), 0);
        check_eq({tag, ".beat"}, int'(beat), 0);
        check_eq({tag, ".playing"}, int'(playing), 0);
        check_eq({tag, ".mute"}, int'(mute), 1);
    endtask

    initial begin
        reset = 1'b1;
        play = 0; stop = 0; nxt = 0; prv = 0; mode = 2'd0; song_end = 0;
        end_at = 127;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // prev wins over play in the same cycle
        cyc(1, 0, 0, 1);
        check_eq("prev_play.song", int'(song), 3);
        check_eq("prev_play.playing", int'(playing), 0);

        // mode 0 on the last song stops and rewinds to song 0
        mode = 2'd0; end_at = 1;
        cyc(1, 0, 0, 0);
        check_eq("start.playing", int'(playing), 1);
        idle(8);
        check_eq("last_end.song", int'(song), 0);
        check_eq("last_end.playing", int'(playing), 0);
        check_eq("last_end.mute", int'(mute), 1);
        check_eq("last_end.beat", int'(beat), 1);
        idle(8);
        check_eq("stopped.addr", int'(note_addr), 0);

        // plain playback: one beat per BD cycles
        end_at = 127;
        cyc(1, 0, 0, 0);
        check_eq("play.addr0", int'(note_addr), 0);
        idle(4);
        check_eq("play.addr1", int'(note_addr), 1);
        check_eq("play.beat1", int'(beat), 1);
        idle(8);
        check_eq("play.addr3", int'(note_addr), 3);
        cyc(0, 1, 0, 0);
        check_eq("stop.addr", int'(note_addr), 0);

        // mode 1: end at addr 5 on song 1 -> song 2, gap, play again
        mode = 2'd1; end_at = 5;
        cyc(0, 0, 1, 0);
        check_eq("next.song", int'(song), 1);
        cyc(1, 0, 0, 0);
        idle(24);
        check_eq("all_end.song", int'(song), 2);
        check_eq("all_end.addr", int'(note_addr), 0);
        check_eq("all_end.playing", int'(playing), 0);
        idle(8);
        check_eq("gap_done.playing", int'(playing), 1);
        check_eq("gap_done.beat", int'(beat), 1);
        cyc(0, 1, 0, 0);

        // pause at count 2, hold, resume: beat one cycle after resume
        end_at = 127;
        cyc(1, 0, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0);
        check_eq("pause.playing", int'(playing), 0);
        idle(10);
        check_eq("pause.addr", int'(note_addr), 0);
        cyc(1, 0, 0, 0);
        check_eq("resume.beat", int'(beat), 0);
        idle(1);
        check_eq("resume.beat_next", int'(beat), 1);
        check_eq("resume.addr", int'(note_addr), 1);
        cyc(0, 1, 0, 0);

        // mode 2 repeats song 2; stop during the gap
        for (int k = 0; k < N && m_song != 2; k++) cyc(0, 0, 1, 0);
        mode = 2'd2; end_at = 1;
        cyc(1, 0, 0, 0);
        idle(8);
        check_eq("one_end.song", int'(song), 2);
        check_eq("one_end.addr", int'(note_addr), 0);
        idle(2);
        cyc(0, 1, 0, 0);
        check_eq("gap_stop.playing", int'(playing), 0);
        check_eq("gap_stop.addr", int'(note_addr), 0);
        idle(8);

        // random traffic against the model, with one asynchronous reset mid-run
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) mode = 2'($urandom_range(0, 3));
            end_at = 2 + 2 * m_song;
            if (i == 1500) begin
                #2 reset = 1'b1;
                #1 check_reset_values("async_reset");
                @(negedge clk);
                reset = 1'b0;
                model_reset();
            end
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 79) == 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
